// File: rtl/matmul_sequencer.sv
`default_nettype none
// =============================================================================
// Module   : matmul_sequencer
// Brief    : Address/strobe sequencer driving a shared MAC for an NxN matmul.
// Revision : 1.0
// =============================================================================
module matmul_sequencer #(
    parameter int N    = 4,
    parameter int DW   = 8,
    parameter int AW   = 16,
    parameter int LOGN = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_rd,
    output logic [2*LOGN-1:0]     a_addr,
    output logic [2*LOGN-1:0]     b_addr,
    input  logic [DW-1:0]         a_data,
    input  logic [DW-1:0]         b_data,
    output logic [DW-1:0]         mac_a,
    output logic [DW-1:0]         mac_b,
    output logic                  mac_en,
    output logic                  mac_clr,
    input  logic [AW-1:0]         mac_result,
    output logic [N*N*AW-1:0]     C_out
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_DRAIN = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [LOGN-1:0] c_last = LOGN'(N - 1);
    localparam logic [LOGN-1:0] c_one  = LOGN'(1);

    state_t            r_state;
    state_t            w_next;
    logic [LOGN-1:0]   r_row;
    logic [LOGN-1:0]   r_col;
    logic [LOGN-1:0]   r_k;
    logic [AW-1:0]     r_c [N*N];

    assign mac_a = a_data;
    assign mac_b = b_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_row <= '0;
            r_col <= '0;
            r_k   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_row <= '0;
                        r_col <= '0;
                        r_k   <= '0;
                    end
                end
                S_RUN: begin
                    r_k <= (r_k == c_last) ? '0 : r_k + c_one;
                end
                S_WRITE: begin
                    r_col <= r_col + c_one;
                    if (r_col == c_last) begin
                        r_row <= r_row + c_one;
                    end
                end
                default: ;
            endcase
        end
    end

    // Read data lags the address by a cycle, so the MAC runs one step behind k.
    always_comb begin
        w_next  = r_state;
        busy    = 1'b0;
        done    = 1'b0;
        mem_rd  = 1'b0;
        a_addr  = '0;
        b_addr  = '0;
        mac_en  = 1'b0;
        mac_clr = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                busy    = 1'b1;
                mem_rd  = 1'b1;
                a_addr  = {r_row, r_k};
                b_addr  = {r_k, r_col};
                mac_en  = (r_k != '0);
                mac_clr = (r_k == c_one);
                if (r_k == c_last) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy   = 1'b1;
                mac_en = 1'b1;
                w_next = S_WRITE;
            end
            S_WRITE: begin
                busy = 1'b1;
                if ((r_row == c_last) && (r_col == c_last)) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_RUN;
                end
            end
            S_DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N*N; i++) begin
                r_c[i] <= '0;
            end
        end else if (r_state == S_WRITE) begin
            r_c[{r_row, r_col}] <= mac_result;
        end
    end

    generate
        for (genvar gi = 0; gi < N*N; gi++) begin : g_pack
            assign C_out[gi*AW +: AW] = r_c[gi];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_matmul_sequencer.sv
`default_nettype none
// =============================================================================
// Module   : tb_matmul_sequencer
// Brief    : Directed bench for matmul_sequencer with memory and MAC models.
// Revision : 1.0
// =============================================================================
module tb_matmul_sequencer;

    localparam int N    = 4;
    localparam int DW   = 8;
    localparam int AW   = 16;
    localparam int LOGN = 2;
    localparam int CW   = N*N*AW;

    logic              clk;
    logic              reset;
    logic              start;
    logic              busy;
    logic              done;
    logic              mem_rd;
    logic [2*LOGN-1:0] a_addr;
    logic [2*LOGN-1:0] b_addr;
    logic [DW-1:0]     a_data = '0;
    logic [DW-1:0]     b_data = '0;
    logic [DW-1:0]     mac_a;
    logic [DW-1:0]     mac_b;
    logic              mac_en;
    logic              mac_clr;
    logic [AW-1:0]     mac_result = '0;
    logic [CW-1:0]     C_out;

    logic [DW-1:0]     mem_a [N*N];
    logic [DW-1:0]     mem_b [N*N];
    logic [AW-1:0]     w_prod;

    logic [3:0]        t_aa  [200];
    logic [3:0]        t_bb  [200];
    logic              t_en  [200];
    logic              t_clr [200];
    logic              t_rd  [200];
    logic              t_busy[200];
    logic              t_done[200];

    int                n_checks = 0;
    int                n_pass   = 0;

    matmul_sequencer #(.N(N), .DW(DW), .AW(AW), .LOGN(LOGN)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .mem_rd     (mem_rd),
        .a_addr     (a_addr),
        .b_addr     (b_addr),
        .a_data     (a_data),
        .b_data     (b_data),
        .mac_a      (mac_a),
        .mac_b      (mac_b),
        .mac_en     (mac_en),
        .mac_clr    (mac_clr),
        .mac_result (mac_result),
        .C_out      (C_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read operand memories and the shared MAC.
    assign w_prod = AW'(mac_a) * AW'(mac_b);
    always @(posedge clk) begin
        if (mem_rd) begin
            a_data <= mem_a[a_addr];
            b_data <= mem_b[b_addr];
        end
        if (mac_en) begin
            mac_result <= mac_clr ? w_prod : mac_result + w_prod;
        end
    end

    task automatic check_val(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CW-1:0] all_fields(input logic [AW-1:0] v);
        logic [CW-1:0] r;
        for (int i = 0; i < N*N; i++) r[i*AW +: AW] = v;
        return r;
    endfunction

    function automatic logic [CW-1:0] index_fields();
        logic [CW-1:0] r;
        for (int i = 0; i < N*N; i++) r[i*AW +: AW] = AW'(i);
        return r;
    endfunction

    task automatic load_identity();
        for (int i = 0; i < N*N; i++) begin
            mem_a[i] = ((i / N) == (i % N)) ? 8'd1 : 8'd0;
            mem_b[i] = DW'(i);
        end
    endtask

    task automatic load_const(input logic [DW-1:0] av, input logic [DW-1:0] bv);
        for (int i = 0; i < N*N; i++) begin
            mem_a[i] = av;
            mem_b[i] = bv;
        end
    endtask

    // Pulse start, then record outputs each cycle (offset 0 = first RUN cycle).
    task automatic run_once(output int done_at);
        done_at = -1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            t_aa[c]   = a_addr;
            t_bb[c]   = b_addr;
            t_en[c]   = mac_en;
            t_clr[c]  = mac_clr;
            t_rd[c]   = mem_rd;
            t_busy[c] = busy;
            t_done[c] = done;
            if (done && done_at < 0) done_at = c;
            if (done_at >= 0 && c == done_at + 1) break;
        end
    endtask

    initial begin
        int d;
        int pulses;
        int high_cycles;
        int d_at[4];
        logic [3:0] exp_a[4];
        logic [3:0] exp_b[4];

        exp_a[0] = 4'd4;  exp_a[1] = 4'd5;  exp_a[2] = 4'd6;  exp_a[3] = 4'd7;
        exp_b[0] = 4'd2;  exp_b[1] = 4'd6;  exp_b[2] = 4'd10; exp_b[3] = 4'd14;

        reset = 1'b0;
        start = 1'b0;
        load_identity();
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy",   busy,    0);
        check_val("rst_done",   done,    0);
        check_val("rst_mem_rd", mem_rd,  0);
        check_val("rst_mac_en", mac_en,  0);
        check_val("rst_clr",    mac_clr, 0);
        check_val("rst_aaddr",  a_addr,  0);
        check_val("rst_baddr",  b_addr,  0);
        check_val("rst_C",      C_out,   0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_val("idle_busy", busy, 0);

        // Identity x index matrix, with a detailed look at element (1,2).
        run_once(d);
        check_val("id_done_cycle", 32'(d), 32'd96);
        check_val("id_C", C_out, index_fields());
        check_val("id_busy_after", t_busy[97], 0);
        check_val("id_done_width", t_done[97], 0);
        for (int k = 0; k < 4; k++) begin
            check_val($sformatf("e12_aaddr_k%0d", k), t_aa[36+k], exp_a[k]);
            check_val($sformatf("e12_baddr_k%0d", k), t_bb[36+k], exp_b[k]);
            check_val($sformatf("e12_rd_k%0d", k),    t_rd[36+k], 1);
        end
        check_val("e12_rd_drain", t_rd[40], 0);
        for (int c = 36; c < 42; c++) begin
            check_val($sformatf("e12_clr_c%0d", c), t_clr[c], (c == 37));
            check_val($sformatf("e12_en_c%0d", c),  t_en[c],  (c >= 37 && c <= 40));
        end

        load_const(8'd2, 8'd3);
        run_once(d);
        check_val("c23_done_cycle", 32'(d), 32'd96);
        check_val("c23_C", C_out, all_fields(16'd24));

        load_const(8'd255, 8'd255);
        run_once(d);
        check_val("c255_done_cycle", 32'(d), 32'd96);
        check_val("c255_C", C_out, all_fields(16'd63492));

        // Asynchronous reset in the middle of a run.
        load_const(8'd2, 8'd3);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (41) @(negedge clk);
        check_val("pre_rst_busy", busy, 1);
        #2 reset = 1'b0;
        #1;
        check_val("mid_rst_busy",   busy,   0);
        check_val("mid_rst_mac_en", mac_en, 0);
        check_val("mid_rst_mem_rd", mem_rd, 0);
        check_val("mid_rst_done",   done,   0);
        check_val("mid_rst_C",      C_out,  0);
        @(negedge clk);
        reset = 1'b1;
        run_once(d);
        check_val("post_rst_done_cycle", 32'(d), 32'd96);
        check_val("post_rst_C", C_out, all_fields(16'd24));

        // start held high: back-to-back runs.
        load_identity();
        pulses      = 0;
        high_cycles = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (done) begin
                high_cycles++;
                if (!t_done[0]) begin
                    if (pulses < 4) d_at[pulses] = c;
                    pulses++;
                    check_val($sformatf("held_C_run%0d", pulses), C_out, index_fields());
                end
            end
            t_done[0] = done;
        end
        start = 1'b0;
        check_val("held_pulses", 32'(pulses), 32'd3);
        check_val("held_high_cycles", 32'(high_cycles), 32'd3);
        check_val("held_first", 32'(d_at[0]), 32'd96);
        check_val("held_gap1", 32'(d_at[1] - d_at[0]), 32'd98);
        check_val("held_gap2", 32'(d_at[2] - d_at[1]), 32'd98);

        repeat (120) @(negedge clk);
        check_val("final_idle_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
